// File: rtl/demod_rr_scheduler.sv
// Round-robin scheduler sharing one complex demod unit among NUM_REQ channel
// streams. One sample is in flight at a time: pop, issue with tag, wait for
// the result, write it back to the owning requester's output FIFOs.
module demod_rr_scheduler #(
  parameter int NUM_REQ = 3,
  parameter int BURST   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        in_empty,
  output logic [NUM_REQ-1:0]        in_rd_en,
  input  logic [NUM_REQ*DATA_W-1:0] in_real_dout,
  input  logic [NUM_REQ*DATA_W-1:0] in_imag_dout,
  output logic                      op_valid,
  input  logic                      op_ready,
  output logic [DATA_W-1:0]         op_real,
  output logic [DATA_W-1:0]         op_imag,
  output logic [TAG_W-1:0]          op_tag,
  input  logic                      res_valid,
  output logic                      res_ready,
  input  logic [DATA_W-1:0]         res_real,
  input  logic [DATA_W-1:0]         res_imag,
  input  logic [TAG_W-1:0]          res_tag,
  input  logic [NUM_REQ-1:0]        out_full,
  output logic [NUM_REQ-1:0]        out_wr_en,
  output logic [DATA_W-1:0]         out_real_din,
  output logic [DATA_W-1:0]         out_imag_din,
  output logic [TAG_W-1:0]          grant,
  output logic                      busy,
  output logic                      tag_err
);

  typedef enum logic [1:0] {ARB = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, WRITE = 2'd3} state_t;

  // Burst counter must reach BURST itself (up to 255) so it can saturate the re-grant test.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] BURST_C = CNT_W'(BURST);

  state_t              state_reg, state_next;
  logic [TAG_W-1:0]    grant_reg, grant_next;
  logic [TAG_W-1:0]    rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]    burst_cnt_reg, burst_cnt_next;
  logic                tag_err_reg, tag_err_next;
  logic [DATA_W-1:0]   op_real_reg, op_real_next, op_imag_reg, op_imag_next;
  logic [DATA_W-1:0]   res_real_reg, res_real_next, res_imag_reg, res_imag_next;

  logic [DATA_W-1:0]   real_slice [NUM_REQ];
  logic [DATA_W-1:0]   imag_slice [NUM_REQ];
  logic [NUM_REQ-1:0]  eligible;
  logic                pick_found, pick_regrant, grant_elig, grant_full, write_fire;
  logic [TAG_W-1:0]    pick_idx, grant_plus1;
  logic [DATA_W-1:0]   sel_real, sel_imag;
  logic [CNT_W-1:0]    burst_inc;
  int                  cand;

  // Unpack the per-requester FWFT data words.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign real_slice[gi] = in_real_dout[gi*DATA_W +: DATA_W];
      assign imag_slice[gi] = in_imag_dout[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign eligible    = ~in_empty & ~out_full;
  assign burst_inc   = burst_cnt_reg + CNT_W'(1);
  assign grant_plus1 = (grant_reg == TAG_W'(NUM_REQ-1)) ? '0 : grant_reg + TAG_W'(1);

  // Arbitration: keep the previous grant inside its burst, else first eligible from rr_ptr.
  always_comb begin
    pick_found   = 1'b0;
    pick_regrant = 1'b0;
    pick_idx     = '0;
    grant_elig   = 1'b0;
    grant_full   = 1'b0;
    sel_real     = '0;
    sel_imag     = '0;
    cand         = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant_reg == TAG_W'(k)) begin
        grant_elig = eligible[k];
        grant_full = out_full[k];
      end
    end
    if (grant_elig && (burst_cnt_reg < BURST_C)) begin
      pick_found   = 1'b1;
      pick_regrant = 1'b1;
      pick_idx     = grant_reg;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = int'(rr_ptr_reg) + i;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!pick_found && (cand == k) && eligible[k]) begin
            pick_found = 1'b1;
            pick_idx   = TAG_W'(k);
          end
        end
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == TAG_W'(k)) begin
        sel_real = real_slice[k];
        sel_imag = imag_slice[k];
      end
    end
  end

  // Next-state logic for the ARB -> ISSUE -> WAIT -> WRITE sample cycle.
  always_comb begin
    state_next     = state_reg;
    grant_next     = grant_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    tag_err_next   = tag_err_reg;
    op_real_next   = op_real_reg;
    op_imag_next   = op_imag_reg;
    res_real_next  = res_real_reg;
    res_imag_next  = res_imag_reg;
    case (state_reg)
      ARB: begin
        if (pick_found) begin
          grant_next   = pick_idx;
          op_real_next = sel_real;
          op_imag_next = sel_imag;
          if (!pick_regrant) burst_cnt_next = '0;
          state_next   = ISSUE;
        end
      end
      ISSUE: begin
        if (op_ready) state_next = WAIT;
      end
      WAIT: begin
        if (res_valid) begin
          res_real_next = res_real;
          res_imag_next = res_imag;
          // A wrong tag is flagged but the result still belongs to the current grant.
          if (res_tag != grant_reg) tag_err_next = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!grant_full) begin
          burst_cnt_next = burst_inc;
          if (burst_inc == BURST_C) rr_ptr_next = grant_plus1;
          state_next = ARB;
        end
      end
      default: state_next = ARB;
    endcase
  end

  // State and datapath registers; reset drops any in-flight sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg     <= ARB;
      grant_reg     <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
      tag_err_reg   <= 1'b0;
      op_real_reg   <= '0;
      op_imag_reg   <= '0;
      res_real_reg  <= '0;
      res_imag_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      grant_reg     <= grant_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      tag_err_reg   <= tag_err_next;
      op_real_reg   <= op_real_next;
      op_imag_reg   <= op_imag_next;
      res_real_reg  <= res_real_next;
      res_imag_reg  <= res_imag_next;
    end
  end

  // One-hot FIFO strobes; held quiet while reset is asserted.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_strobe
      assign in_rd_en[gi]  = !reset && (state_reg == ARB) && pick_found && (pick_idx == TAG_W'(gi));
      assign out_wr_en[gi] = !reset && (state_reg == WRITE) && (grant_reg == TAG_W'(gi)) && !out_full[gi];
    end
  endgenerate

  assign write_fire   = (state_reg == WRITE) && !grant_full;
  assign out_real_din = write_fire ? res_real_reg : '0;
  assign out_imag_din = write_fire ? res_imag_reg : '0;
  assign op_valid     = (state_reg == ISSUE);
  assign res_ready    = (state_reg == WAIT);
  assign op_real      = op_real_reg;
  assign op_imag      = op_imag_reg;
  assign op_tag       = grant_reg;
  assign grant        = grant_reg;
  assign busy         = (state_reg != ARB);
  assign tag_err      = tag_err_reg;

endmodule

// File: tb/tb_demod_rr_scheduler.sv
// Self-checking bench for demod_rr_scheduler: FIFO/demod-unit environment,
// a transaction-level reference model compared every cycle, directed cases
// with literal expectations, then a randomized run with an end-to-end scoreboard.
module tb_demod_rr_scheduler;
  localparam int N = 3, BURST = 4, DW = 32, TW = 3;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic [N-1:0] in_empty, in_rd_en, out_full, out_wr_en;
  logic [N*DW-1:0] in_real_dout, in_imag_dout;
  logic op_valid, op_ready, res_valid, res_ready, busy, tag_err;
  logic [DW-1:0] op_real, op_imag, res_real, res_imag, out_real_din, out_imag_din;
  logic [TW-1:0] op_tag, res_tag, grant;

  always #5 clock = ~clock;

  demod_rr_scheduler #(.NUM_REQ(N), .BURST(BURST), .DATA_W(DW), .TAG_W(TW)) dut (
    .clock(clock), .reset(reset), .in_empty(in_empty), .in_rd_en(in_rd_en),
    .in_real_dout(in_real_dout), .in_imag_dout(in_imag_dout),
    .op_valid(op_valid), .op_ready(op_ready), .op_real(op_real), .op_imag(op_imag),
    .op_tag(op_tag), .res_valid(res_valid), .res_ready(res_ready), .res_real(res_real),
    .res_imag(res_imag), .res_tag(res_tag), .out_full(out_full), .out_wr_en(out_wr_en),
    .out_real_din(out_real_din), .out_imag_din(out_imag_din), .grant(grant),
    .busy(busy), .tag_err(tag_err)
  );

  int errors = 0, checks = 0, cycle = 0;

  // Environment: input FIFOs, expected/observed output FIFOs, logs
  int in_q_re[N][$], in_q_im[N][$];
  int exp_re[N][$], exp_im[N][$];
  int out_re[N][$], out_im[N][$];
  int wr_cyc[N][$];
  int pop_log[$];

  // Stimulus knobs
  bit [N-1:0] drv_full;
  bit drv_op_ready, mode, lat_rand, bad_tag_en;
  int lat_fixed, bad_tag_val;

  // Shared demod unit model
  bit u_pend;
  int u_cnt, u_re, u_im, u_tag;

  // Reference model: one sample record plus arbitration bookkeeping
  bit m_active, m_issued, m_returned, m_err, m_regrant;
  int m_last, m_cnt, m_ptr, m_pick, m_op_re, m_op_im, m_res_re, m_res_im;

  // Captured DUT strobes for the environment
  logic [N-1:0] cap_rd, cap_wr;
  logic cap_ov, cap_rr;
  int cap_ore, cap_oim, cap_tag, cap_dre, cap_dim;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cycle, act, exp);
    end
  endtask

  function automatic int fre(input int v);
    return mode ? v + 100 : v;
  endfunction

  function automatic int fim(input int v);
    return mode ? v - 7 : v;
  endfunction

  function automatic bit elig(input int k);
    return (in_q_re[k].size() > 0) && !drv_full[k];
  endfunction

  task automatic push(input int k, input int re, input int im);
    in_q_re[k].push_back(re);
    in_q_im[k].push_back(im);
  endtask

  task automatic clear_env();
    for (int k = 0; k < N; k++) begin
      in_q_re[k].delete(); in_q_im[k].delete();
      exp_re[k].delete(); exp_im[k].delete();
      out_re[k].delete(); out_im[k].delete();
      wr_cyc[k].delete();
    end
    pop_log.delete();
    u_pend = 0; u_cnt = 0; u_re = 0; u_im = 0; u_tag = 0;
    m_active = 0; m_issued = 0; m_returned = 0; m_err = 0; m_regrant = 0;
    m_last = 0; m_cnt = 0; m_ptr = 0; m_pick = -1;
    m_op_re = 0; m_op_im = 0; m_res_re = 0; m_res_im = 0;
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      in_empty[k] = (in_q_re[k].size() == 0);
      in_real_dout[k*DW +: DW] = in_empty[k] ? 32'd0 : in_q_re[k][0];
      in_imag_dout[k*DW +: DW] = in_empty[k] ? 32'd0 : in_q_im[k][0];
    end
    out_full  = drv_full;
    op_ready  = drv_op_ready;
    res_valid = u_pend && (u_cnt == 0);
    res_real  = u_re;
    res_imag  = u_im;
    res_tag   = TW'(u_tag);
  endtask

  // First half of a cycle: drive, then compare every output with the model at the negedge.
  task automatic half1();
    int e_rd, e_wr, e_ov, e_rr, e_dre, e_dim;
    drive();
    @(negedge clock);
    e_rd = 0; e_wr = 0; e_ov = 0; e_rr = 0; e_dre = 0; e_dim = 0;
    m_pick = -1; m_regrant = 0;
    if (!m_active) begin
      if (elig(m_last) && m_cnt < BURST) begin
        m_pick = m_last; m_regrant = 1;
      end else begin
        for (int i = 0; i < N; i++)
          if (m_pick < 0 && elig((m_ptr + i) % N)) m_pick = (m_ptr + i) % N;
      end
      if (m_pick >= 0) e_rd = 1 << m_pick;
    end else if (!m_issued) e_ov = 1;
    else if (!m_returned) e_rr = 1;
    else if (!drv_full[m_last]) begin
      e_wr = 1 << m_last; e_dre = m_res_re; e_dim = m_res_im;
    end
    chk("in_rd_en", in_rd_en, e_rd);
    chk("out_wr_en", out_wr_en, e_wr);
    chk("op_valid", op_valid, e_ov);
    chk("res_ready", res_ready, e_rr);
    chk("op_real", $signed(op_real), m_op_re);
    chk("op_imag", $signed(op_imag), m_op_im);
    chk("op_tag", op_tag, m_last);
    chk("out_real_din", $signed(out_real_din), e_dre);
    chk("out_imag_din", $signed(out_imag_din), e_dim);
    chk("grant", grant, m_last);
    chk("busy", busy, m_active);
    chk("tag_err", tag_err, m_err);
    cap_rd = in_rd_en; cap_wr = out_wr_en; cap_ov = op_valid; cap_rr = res_ready;
    cap_ore = $signed(op_real); cap_oim = $signed(op_imag); cap_tag = op_tag;
    cap_dre = $signed(out_real_din); cap_dim = $signed(out_imag_din);
  endtask

  // Second half: clock edge, then advance the model and the environment.
  task automatic half2();
    @(posedge clock);
    #1;
    cycle++;
    if (!m_active) begin
      if (m_pick >= 0) begin
        if (!m_regrant) m_cnt = 0;
        m_last = m_pick;
        m_op_re = in_q_re[m_pick][0];
        m_op_im = in_q_im[m_pick][0];
        m_active = 1;
      end
    end else if (!m_issued) begin
      if (drv_op_ready) m_issued = 1;
    end else if (!m_returned) begin
      if (res_valid) begin
        m_returned = 1; m_res_re = u_re; m_res_im = u_im;
        if (u_tag != m_last) m_err = 1;
      end
    end else if (!drv_full[m_last]) begin
      m_cnt++;
      if (m_cnt == BURST) m_ptr = (m_last + 1) % N;
      m_active = 0; m_issued = 0; m_returned = 0;
    end
    for (int k = 0; k < N; k++) begin
      if (cap_rd[k] && in_q_re[k].size() > 0) begin
        exp_re[k].push_back(fre(in_q_re[k][0]));
        exp_im[k].push_back(fim(in_q_im[k][0]));
        void'(in_q_re[k].pop_front());
        void'(in_q_im[k].pop_front());
        pop_log.push_back(k);
      end
      if (cap_wr[k]) begin
        out_re[k].push_back(cap_dre);
        out_im[k].push_back(cap_dim);
        wr_cyc[k].push_back(cycle);
        if (exp_re[k].size() == 0) chk("sb_unexpected_write", k, -1);
        else begin
          chk("sb_real", cap_dre, exp_re[k].pop_front());
          chk("sb_imag", cap_dim, exp_im[k].pop_front());
        end
      end
    end
    if (res_valid && cap_rr) u_pend = 0;
    if (cap_ov && drv_op_ready && !u_pend) begin
      u_pend = 1;
      u_cnt  = lat_rand ? int'($urandom_range(0, 3)) : lat_fixed;
      u_re   = fre(cap_ore);
      u_im   = fim(cap_oim);
      u_tag  = bad_tag_en ? bad_tag_val : cap_tag;
    end else if (u_pend && u_cnt > 0) u_cnt--;
  endtask

  task automatic step();
    half1();
    half2();
  endtask

  // Asynchronous reset mid-cycle; every output must drop within the same cycle.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    chk("rst_in_rd_en", in_rd_en, 0);
    chk("rst_out_wr_en", out_wr_en, 0);
    chk("rst_op_valid", op_valid, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_op_real", op_real, 0);
    chk("rst_op_imag", op_imag, 0);
    chk("rst_op_tag", op_tag, 0);
    chk("rst_out_real_din", out_real_din, 0);
    chk("rst_out_imag_din", out_imag_din, 0);
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_tag_err", tag_err, 0);
    repeat (2) @(posedge clock);
    #1;
    clear_env();
    reset = 1'b0;
  endtask

  task automatic run_until_writes(input int k, input int n, input int budget);
    int b;
    b = budget;
    while (out_re[k].size() < n && b > 0) begin
      step();
      b--;
    end
    if (out_re[k].size() < n) chk("timeout_writes", out_re[k].size(), n);
  endtask

  task automatic run_until_issued(input int budget);
    int b;
    b = budget;
    while (!m_issued && b > 0) begin
      step();
      b--;
    end
    if (!m_issued) chk("timeout_issue", m_issued, 1);
  endtask

  initial begin
    int t1_re[3], t1_im[3], t2_seq[14];
    int b;
    t1_re = '{10, 5, -7};
    t1_im = '{-2, 5, 1};
    t2_seq = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0, 0};
    drv_full = '0; drv_op_ready = 1; mode = 0; lat_fixed = 0; lat_rand = 0;
    bad_tag_en = 0; bad_tag_val = 0;
    clear_env();
    drive();
    do_reset();

    // Single requester, echo unit, minimum latency
    push(1, 10, -2); push(1, 5, 5); push(1, -7, 1);
    run_until_writes(1, 3, 60);
    chk("t1_pops", pop_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      if (pop_log.size() > i) chk("t1_pop_idx", pop_log[i], 1);
      if (out_re[1].size() > i) begin
        chk("t1_re", out_re[1][i], t1_re[i]);
        chk("t1_im", out_im[1][i], t1_im[i]);
      end
    end
    for (int i = 1; i < 3; i++)
      if (wr_cyc[1].size() > i) chk("t1_spacing", wr_cyc[1][i] - wr_cyc[1][i-1], 4);

    // All requesters busy: burst-of-4 round robin with pointer wrap
    do_reset();
    b = 200;
    while (pop_log.size() < 14 && b > 0) begin
      for (int k = 0; k < N; k++)
        if (in_q_re[k].size() < 2) push(k, int'($urandom_range(0, 1000)), -int'($urandom_range(0, 1000)));
      step();
      b--;
    end
    chk("t2_pop_count", pop_log.size() >= 14, 1);
    for (int i = 0; i < 14; i++)
      if (pop_log.size() > i) chk("t2_grant_seq", pop_log[i], t2_seq[i]);

    // Output full held during WRITE
    do_reset();
    push(1, 42, -42);
    run_until_issued(20);
    drv_full[1] = 1;
    repeat (9) step();
    half1();
    chk("t3_busy_held", busy, 1);
    chk("t3_wr_held", out_wr_en, 0);
    chk("t3_no_write", out_re[1].size(), 0);
    half2();
    drv_full[1] = 0;
    half1();
    chk("t3_wr_release", out_wr_en, 3'b010);
    chk("t3_din_release", $signed(out_real_din), 42);
    half2();

    // op_ready stalled in ISSUE
    do_reset();
    drv_op_ready = 0;
    push(0, 123, -45);
    step();
    repeat (5) begin
      half1();
      chk("t4_op_valid", op_valid, 1);
      chk("t4_op_real", $signed(op_real), 123);
      chk("t4_op_imag", $signed(op_imag), -45);
      chk("t4_op_tag", op_tag, 0);
      chk("t4_no_pop", in_rd_en, 0);
      half2();
    end
    drv_op_ready = 1;
    run_until_writes(0, 1, 20);

    // Wrong tag returned: sticky flag, data still to requester 0
    bad_tag_en = 1; bad_tag_val = 2;
    push(0, 7, 8);
    run_until_writes(0, 2, 20);
    chk("t5_tag_err", tag_err, 1);
    if (out_re[0].size() > 1) begin
      chk("t5_re", out_re[0][1], 7);
      chk("t5_im", out_im[0][1], 8);
    end
    bad_tag_en = 0;
    push(0, 9, 9);
    run_until_writes(0, 3, 20);
    chk("t5_tag_err_sticky", tag_err, 1);

    // Reset during WAIT with a non-zero round-robin pointer
    do_reset();
    for (int i = 0; i < 4; i++) push(1, i, i);
    run_until_writes(1, 4, 80);
    lat_fixed = 6;
    push(2, 11, 12);
    run_until_issued(20);
    step();
    do_reset();
    lat_fixed = 0;
    push(1, 1, 1); push(2, 2, 2);
    half1();
    chk("t6_grant_after_reset", in_rd_en, 3'b010);
    half2();
    run_until_writes(1, 1, 20);

    // Randomized traffic against the model and scoreboard
    do_reset();
    mode = 1; lat_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if (in_q_re[k].size() < 4 && $urandom_range(0, 99) < 35)
          push(k, int'($urandom_range(0, 200000)) - 100000, int'($urandom_range(0, 200000)) - 100000);
        drv_full[k] = ($urandom_range(0, 99) < 20);
      end
      drv_op_ready = ($urandom_range(0, 99) < 65);
      step();
    end
    drv_full = '0; drv_op_ready = 1;
    b = 300;
    while ((in_q_re[0].size() + in_q_re[1].size() + in_q_re[2].size() > 0 || m_active) && b > 0) begin
      step();
      b--;
    end
    chk("t7_drained", m_active, 0);
    for (int k = 0; k < N; k++) begin
      chk("t7_in_left", in_q_re[k].size(), 0);
      chk("t7_sb_left", exp_re[k].size(), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog cycle=%0d actual=running required=finished", cycle);
    $fatal(1, "watchdog expired");
  end

endmodule
